rhs_extend_packer: RTL and testbench



---
 rtl/rhs_extend_packer.sv | 109 ++++++++++
 tb/tb_rhs_extend_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rhs_extend_packer.sv
// Widening stream stage: packs RATIO narrow words into one wide word (pack mode) or
// zero/sign-extends each narrow word on its own (extend mode), with one output register.
module rhs_extend_packer #(
  parameter int W_IN  = 3,
  parameter int RATIO = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W_IN-1:0]              in_data,
  input  logic                         in_last,
  input  logic                         ext_mode,
  input  logic                         sign_ext,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W_IN*RATIO-1:0]        out_data,
  output logic [$clog2(RATIO+1)-1:0]   out_count
);
  localparam int W_OUT = W_IN * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  // The output register never holds a word while a group is partly filled,
  // so the three states are mutually exclusive.
  typedef enum logic [1:0] {EMPTY, FILL, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_fill, w_fill_nxt;
  logic [W_OUT-1:0] r_acc, w_acc_nxt;
  logic [W_OUT-1:0] r_out_data, w_out_data_nxt;
  logic [CW-1:0]    r_out_count, w_out_count_nxt;
  logic             r_ext, w_ext_nxt;
  logic             r_sgn, w_sgn_nxt;

  logic             w_xfer, w_first, w_ext, w_sgn, w_complete, w_fill_bit;
  logic [CW-1:0]    w_k;
  logic [W_OUT-1:0] w_base, w_acc_cur, w_hi_mask, w_packed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_fill      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_ext       <= 1'b0;
      r_sgn       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill      <= w_fill_nxt;
      r_acc       <= w_acc_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_count <= w_out_count_nxt;
      r_ext       <= w_ext_nxt;
      r_sgn       <= w_sgn_nxt;
    end
  end

  // Modes come from the ports on the first word of a group, from the latch afterwards.
  // Extend mode is a one-word pack, so both share the slot/fill datapath.
  always_comb begin
    w_xfer     = in_valid && in_ready;
    w_first    = (r_fill == '0);
    w_ext      = w_first ? ext_mode : r_ext;
    w_sgn      = w_first ? sign_ext : r_sgn;
    w_k        = w_ext ? '0 : r_fill;
    w_base     = (w_first || w_ext) ? '0 : r_acc;
    w_acc_cur  = w_base | (W_OUT'(in_data) << (32'(w_k) * W_IN));
    w_hi_mask  = {W_OUT{1'b1}} << ((32'(w_k) + 32'd1) * W_IN);
    w_fill_bit = w_sgn && in_data[W_IN-1];
    w_packed   = w_acc_cur | (w_fill_bit ? w_hi_mask : '0);
    w_complete = w_xfer && (w_ext || in_last || (r_fill == CW'(RATIO - 1)));

    w_state_nxt     = r_state;
    w_fill_nxt      = r_fill;
    w_acc_nxt       = r_acc;
    w_out_data_nxt  = r_out_data;
    w_out_count_nxt = r_out_count;
    w_ext_nxt       = r_ext;
    w_sgn_nxt       = r_sgn;

    if (w_xfer && w_first) begin
      w_ext_nxt = ext_mode;
      w_sgn_nxt = sign_ext;
    end

    if (w_complete) begin
      w_state_nxt     = HOLD;
      w_out_data_nxt  = w_packed;
      w_out_count_nxt = w_k + CW'(1);
      w_fill_nxt      = '0;
      w_acc_nxt       = '0;
    end else if (w_xfer) begin
      w_state_nxt = FILL;
      w_fill_nxt  = r_fill + CW'(1);
      w_acc_nxt   = w_acc_cur;
    end else if (out_valid && out_ready) begin
      w_state_nxt = EMPTY;
    end
  end

  always_comb begin
    out_valid = (r_state == HOLD);
    in_ready  = !rst && (!out_valid || out_ready);
    out_data  = r_out_data;
    out_count = r_out_count;
  end

endmodule

// File: tb/tb_rhs_extend_packer.sv
// Bench for rhs_extend_packer: directed vector table, hand-written corner sequences and a
// random phase, all watched by a transaction-level scoreboard of the pack/extend rules.
module tb_rhs_extend_packer;
  localparam int W_IN  = 3;
  localparam int RATIO = 4;
  localparam int W_OUT = W_IN * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last, ext_mode, sign_ext;
  logic             out_valid, out_ready;
  logic [W_IN-1:0]  in_data;
  logic [W_OUT-1:0] out_data;
  logic [CW-1:0]    out_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic                    ext;
    logic                    sgn;
    logic                    flip;
    logic                    last;
    logic [2:0]              n;
    logic [RATIO*W_IN-1:0]   words;
    logic [W_OUT-1:0]        expData;
    logic [CW-1:0]           expCount;
  } vec_t;

  vec_t vecs[12];

  int unsigned      grp[$];
  logic [W_OUT-1:0] expData[$];
  logic [CW-1:0]    expCount[$];
  logic             mExt, mSgn;

  always #5 clk = ~clk;

  rhs_extend_packer #(.W_IN(W_IN), .RATIO(RATIO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .ext_mode(ext_mode), .sign_ext(sign_ext),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic ext, input logic sgn, input logic flip,
                                 input logic last, input int n, input logic [11:0] words,
                                 input logic [11:0] expD, input int expC);
    vec_t v;
    v.ext = ext; v.sgn = sgn; v.flip = flip; v.last = last;
    v.n = 3'(n); v.words = words; v.expData = expD; v.expCount = CW'(expC);
    return v;
  endfunction

  // Expected output from the group rules: word k is worth word*2^(k*W_IN); a sign fill
  // adds 2^W_OUT - 2^(n*W_IN), i.e. ones above the filled part, modulo 2^W_OUT.
  always @(negedge clk) begin : scoreboard
    longint v;
    int     n;
    if (rst) begin
      grp.delete(); expData.delete(); expCount.delete();
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 0);
    end else begin
      checkOutput("sb_out_valid", out_valid, expData.size() != 0);
      checkOutput("sb_in_ready", in_ready, (expData.size() == 0) || out_ready);
      if (expData.size() != 0) begin
        checkOutput("sb_out_data", out_data, expData[0]);
        checkOutput("sb_out_count", out_count, expCount[0]);
        if (out_ready) begin
          void'(expData.pop_front());
          void'(expCount.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (grp.size() == 0) begin
          mExt = ext_mode;
          mSgn = sign_ext;
        end
        grp.push_back(32'(in_data));
        if (mExt || in_last || grp.size() == RATIO) begin
          n = grp.size();
          v = 0;
          for (int k = 0; k < n; k++) v += longint'(grp[k]) * (longint'(1) << (k * W_IN));
          if (mSgn && grp[n-1] >= (1 << (W_IN - 1)))
            v += (longint'(1) << W_OUT) - (longint'(1) << (n * W_IN));
          expData.push_back(W_OUT'(v));
          expCount.push_back(CW'(n));
          grp.delete();
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the word was taken.
  task automatic waitXfer();
    int t = 0;
    @(negedge clk);
    while (!(in_valid && in_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) checkOutput("xfer_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) begin
      in_valid = 1'b1;
      in_data  = v.words[i*W_IN +: W_IN];
      in_last  = v.last && (i == int'(v.n) - 1);
      ext_mode = v.ext ^ (v.flip && i > 0);
      sign_ext = v.sgn ^ (v.flip && i > 0);
      waitXfer();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic checkVector(input string name, input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput({name, "_valid"}, out_valid, 1);
    checkOutput({name, "_data"}, out_data, v.expData);
    checkOutput({name, "_count"}, out_count, v.expCount);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t cont;
    vecs[0]  = mkVec(0, 0, 0, 0, 4, {3'd4, 3'd3, 3'd2, 3'd1}, 12'h8D1, 4);
    vecs[1]  = mkVec(0, 1, 0, 1, 2, {3'd0, 3'd0, 3'd6, 3'd5}, 12'hFF5, 2);
    vecs[2]  = mkVec(0, 0, 0, 1, 2, {3'd0, 3'd0, 3'd6, 3'd5}, 12'h035, 2);
    vecs[3]  = mkVec(0, 1, 1, 1, 2, {3'd0, 3'd0, 3'd6, 3'd5}, 12'hFF5, 2);
    vecs[4]  = mkVec(0, 0, 1, 1, 2, {3'd0, 3'd0, 3'd6, 3'd5}, 12'h035, 2);
    vecs[5]  = mkVec(1, 1, 0, 0, 1, {3'd0, 3'd0, 3'd0, 3'd5}, 12'hFFD, 1);
    vecs[6]  = mkVec(1, 0, 0, 0, 1, {3'd0, 3'd0, 3'd0, 3'd5}, 12'h005, 1);
    vecs[7]  = mkVec(0, 1, 0, 1, 4, {3'd7, 3'd3, 3'd2, 3'd1}, 12'hED1, 4);
    vecs[8]  = mkVec(0, 1, 0, 1, 1, {3'd0, 3'd0, 3'd0, 3'd4}, 12'hFFC, 1);
    vecs[9]  = mkVec(0, 1, 0, 1, 3, {3'd0, 3'd3, 3'd7, 3'd7}, 12'h0FF, 3);
    vecs[10] = mkVec(0, 1, 0, 0, 4, {3'd4, 3'd3, 3'd2, 3'd1}, 12'h8D1, 4);
    vecs[11] = mkVec(1, 0, 0, 1, 1, {3'd0, 3'd0, 3'd0, 3'd6}, 12'h006, 1);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    ext_mode = 1'b0; sign_ext = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_count", out_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) checkVector($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back extend words 7 then 0 on consecutive cycles
    in_valid = 1'b1; ext_mode = 1'b1; sign_ext = 1'b1; in_data = 3'd7;
    waitXfer();
    in_data = 3'd0;
    @(negedge clk);
    checkOutput("b2b_first_data", out_data, 12'hFFF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_second_valid", out_valid, 1);
    checkOutput("b2b_second_data", out_data, 12'h000);
    @(posedge clk); #1;

    // Backpressure: full group held, new word waiting, then simultaneous handshake
    checkVector("bp_group", vecs[0]);
    applyStimulus(vecs[0]);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 3'd7; in_last = 1'b0; ext_mode = 1'b0; sign_ext = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_hold_data", out_data, 12'h8D1);
      checkOutput("bp_hold_count", out_count, 4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_valid_dropped", out_valid, 0);
    @(posedge clk); #1;
    cont = mkVec(0, 0, 0, 0, 3, {3'd0, 3'd3, 3'd2, 3'd1}, 12'h68F, 4);
    checkVector("bp_continue", cont);

    // Async reset between edges with a partial group in flight
    applyStimulus(mkVec(0, 1, 0, 0, 2, {3'd0, 3'd0, 3'd6, 3'd5}, 12'h000, 0));
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_out_count", out_count, 0);
    checkOutput("arst_out_data", out_data, 0);
    checkOutput("arst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkVector("arst_after", vecs[0]);

    // Extend stream with continuous handshakes on both sides: no bubbles
    in_valid = 1'b1; ext_mode = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data  = W_IN'($urandom);
      sign_ext = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("reload_in_ready", in_ready, 1);
      if (c > 0) checkOutput("reload_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Random traffic, judged by the scoreboard
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W_IN'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      ext_mode  = ($urandom_range(0, 2) == 0);
      sign_ext  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
